// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size codes, MMIO offsets, STATUS bits and load extraction for data_mem_ctrl
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

  localparam logic [15:0] OFF_TX     = 16'h0;
  localparam logic [15:0] OFF_STATUS = 16'h4;
  localparam logic [15:0] OFF_CYCLE  = 16'h8;

  localparam int ST_TX_VALID   = 0;
  localparam int ST_MISALIGNED = 1;
  localparam int ST_TX_OVERRUN = 2;

  // Right-justify the addressed byte/half of a RAM word and sign-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input size_e       size);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: result = {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = {{16{shifted[15]}}, shifted[15:0]};
      SZ_WORD: result = word;
      default: result = '0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mmio_tx_buffer.sv
// rtl/mmio_tx_buffer.sv - one-entry TX byte holding register with valid/ready handshake and sticky overrun
module mmio_tx_buffer (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_overrun
);

  logic complete;

  assign complete = tx_valid & tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      tx_overrun <= 1'b0;
    end else if (wr_en) begin
      // A byte leaving on this edge frees the slot for the incoming one.
      if (!tx_valid || complete) begin
        tx_data  <= wr_data;
        tx_valid <= 1'b1;
      end else begin
        tx_overrun <= 1'b1;
      end
    end else if (complete) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data RAM with byte lanes plus MMIO window; optional counter via DMEM_CYCLE_COUNTER_EN
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_addr,
  input  logic [31:0] data_mem_in,
  input  logic [1:0]  rw_data_size,
  input  logic        data_mem_write_enable,
  input  logic        data_mem_read_enable,
  output logic [31:0] data_mem_out,
  output logic        misaligned_err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  size_e         size;
  logic          is_mmio;
  logic          active;
  logic          misaligned;
  logic          mis_access;
  logic          ram_we;
  logic          ram_re;
  logic          mmio_re;
  logic          tx_wr;
  logic          tx_overrun;
  logic [AW-1:0] idx;
  logic [15:0]   off;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rd_word;
  logic [31:0]   mmio_rdata;
  logic [31:0]   cycle_val;

  assign size    = size_e'(rw_data_size);
  assign is_mmio = (d_addr[31:16] == MMIO_BASE[31:16]);
  assign off     = d_addr[15:0];
  assign idx     = d_addr[AW+1:2];
  assign active  = (size != SZ_NONE);
  assign rd_word = mem[idx];

  always_comb begin
    misaligned = 1'b0;
    be         = 4'b0000;
    wdata      = data_mem_in;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << d_addr[1:0];
        wdata = {4{data_mem_in[7:0]}};
      end
      SZ_HALF: begin
        misaligned = d_addr[0];
        be         = d_addr[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{data_mem_in[15:0]}};
      end
      SZ_WORD: begin
        misaligned = |d_addr[1:0];
        be         = 4'b1111;
      end
      default: ;
    endcase
  end

  // Alignment only matters for RAM; MMIO registers ignore the low address bits' alignment.
  assign mis_access = !is_mmio && active && misaligned &&
                      (data_mem_write_enable || data_mem_read_enable);
  assign ram_we  = !is_mmio && active && data_mem_write_enable && !misaligned;
  assign ram_re  = !is_mmio && active && data_mem_read_enable;
  assign mmio_re = is_mmio && active && data_mem_read_enable;
  assign tx_wr   = is_mmio && active && data_mem_write_enable && (off == OFF_TX);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign cycle_val = cycle_cnt;
`else
  assign cycle_val = '0;
`endif

  always_comb begin
    mmio_rdata = '0;
    case (off)
      OFF_STATUS: begin
        mmio_rdata[ST_TX_VALID]   = tx_valid;
        mmio_rdata[ST_MISALIGNED] = misaligned_err;
        mmio_rdata[ST_TX_OVERRUN] = tx_overrun;
      end
      OFF_CYCLE: mmio_rdata = cycle_val;
      default:   ;
    endcase
  end

  // rd_word is the pre-write contents, so a same-edge store never leaks into the load.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_mem_out   <= '0;
      misaligned_err <= 1'b0;
    end else begin
      if (mis_access) misaligned_err <= 1'b1;
      if (ram_re) begin
        data_mem_out <= misaligned ? 32'd0 : load_extract(rd_word, d_addr[1:0], size);
      end else if (mmio_re) begin
        data_mem_out <= mmio_rdata;
      end
    end
  end

  mmio_tx_buffer u_tx (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (tx_wr),
    .wr_data    (data_mem_in[7:0]),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_overrun (tx_overrun)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl against a byte-array reference model
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] d_addr = '0;
  logic [31:0] data_mem_in = '0;
  logic [1:0]  rw_data_size = '0;
  logic        data_mem_write_enable = 1'b0;
  logic        data_mem_read_enable = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] data_mem_out;
  logic        misaligned_err;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mref [4096];
  logic [31:0] m_out;
  logic        m_mis;
  logic        m_valid;
  logic        m_overrun;
  logic [7:0]  m_txd;
  logic [31:0] m_cycle;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  data_mem_ctrl dut (
    .clk                   (clk),
    .reset                 (reset),
    .d_addr                (d_addr),
    .data_mem_in           (data_mem_in),
    .rw_data_size          (rw_data_size),
    .data_mem_write_enable (data_mem_write_enable),
    .data_mem_read_enable  (data_mem_read_enable),
    .data_mem_out          (data_mem_out),
    .misaligned_err        (misaligned_err),
    .tx_data               (tx_data),
    .tx_valid              (tx_valid),
    .tx_ready              (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("data_mem_out", data_mem_out, m_out);
    chk("misaligned_err", {31'd0, misaligned_err}, {31'd0, m_mis});
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_valid});
    chk("tx_data", {24'd0, tx_data}, {24'd0, m_txd});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    data_mem_write_enable = 1'b0;
    data_mem_read_enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_out = '0;
    m_mis = 1'b0;
    m_valid = 1'b0;
    m_overrun = 1'b0;
    m_txd = '0;
    m_cycle = '0;
    check_all();
  endtask

  // One clock of traffic: the model predicts the edge from the access rules, then the DUT is checked.
  task automatic step(input logic w, input logic r, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d, input logic rdy);
    logic        mmio;
    logic        bad;
    logic        done;
    int          nb;
    logic [31:0] v;
    data_mem_write_enable = w;
    data_mem_read_enable = r;
    rw_data_size = sz;
    d_addr = a;
    data_mem_in = d;
    tx_ready = rdy;

    mmio = (a[31:16] == 16'hFFFF);
    nb = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
    bad = !mmio && sz != 2'd0 && (w || r) && ((sz == 2'd2 && a[0]) || (sz == 2'd3 && a[1:0] != 2'd0));

    if (r && sz != 2'd0) begin
      if (mmio) begin
        case (a[15:0])
          16'h4:   m_out = {29'd0, m_overrun, m_mis, m_valid};
`ifdef DMEM_CYCLE_COUNTER_EN
          16'h8:   m_out = m_cycle;
`endif
          default: m_out = '0;
        endcase
      end else if (bad) begin
        m_out = '0;
      end else begin
        v = '0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = mref[a[11:0] + 12'(k)];
        if (nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8*nb));
        m_out = v;
      end
    end

    done = m_valid && rdy;
    if (mmio && w && sz != 2'd0 && a[15:0] == 16'h0) begin
      if (!m_valid || done) begin
        m_valid = 1'b1;
        m_txd = d[7:0];
      end else begin
        m_overrun = 1'b1;
      end
    end else if (done) begin
      m_valid = 1'b0;
    end

    if (!mmio && w && sz != 2'd0 && !bad) begin
      for (int k = 0; k < nb; k++) mref[a[11:0] + 12'(k)] = d[8*k +: 8];
    end
    if (bad) m_mis = 1'b1;
    m_cycle = m_cycle + 32'd1;

    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  pick;
    #1;
    do_reset();

    step(1, 0, 3, 32'h100, 32'hDEADBEEF, 0);
    step(0, 1, 1, 32'h100, 0, 0); chk("lb_100", data_mem_out, 32'hFFFFFFEF);
    step(0, 1, 1, 32'h101, 0, 0); chk("lb_101", data_mem_out, 32'hFFFFFFBE);
    step(0, 1, 1, 32'h102, 0, 0); chk("lb_102", data_mem_out, 32'hFFFFFFAD);
    step(0, 1, 1, 32'h103, 0, 0); chk("lb_103", data_mem_out, 32'hFFFFFFDE);
    step(0, 1, 2, 32'h102, 0, 0); chk("lh_102", data_mem_out, 32'hFFFFDEAD);
    step(1, 0, 1, 32'h101, 32'h7F, 0);
    step(0, 1, 3, 32'h100, 0, 0); chk("lw_after_sb", data_mem_out, 32'hDEAD7FEF);
    step(0, 0, 0, 32'h0, 0, 0);   chk("hold_out", data_mem_out, 32'hDEAD7FEF);
    step(1, 0, 2, 32'h103, 32'h1234, 0);
    chk("mis_set", {31'd0, misaligned_err}, 32'd1);
    step(0, 1, 3, 32'h100, 0, 0); chk("lw_unchanged", data_mem_out, 32'hDEAD7FEF);
    step(0, 1, 3, MB | 32'h4, 0, 0); chk("status_mis", data_mem_out, 32'h2);
    step(0, 1, 3, 32'h106, 0, 0); chk("lw_misaligned", data_mem_out, 32'h0);
    step(1, 0, 3, 32'h1000, 32'h11223344, 0);
    step(0, 1, 3, 32'h0, 0, 0);   chk("alias", data_mem_out, 32'h11223344);
    step(1, 1, 3, 32'h0, 32'hCAFEF00D, 0); chk("rw_same_word", data_mem_out, 32'h11223344);

    do_reset();
    chk("mis_cleared", {31'd0, misaligned_err}, 32'd0);
    step(1, 0, 1, MB, 32'h41, 0);
    chk("tx_valid_1", {31'd0, tx_valid}, 32'd1);
    chk("tx_data_41", {24'd0, tx_data}, 32'h41);
    step(1, 0, 1, MB, 32'h42, 0);  chk("tx_drop", {24'd0, tx_data}, 32'h41);
    step(0, 1, 3, MB | 32'h4, 0, 0); chk("status_ovr", data_mem_out, 32'h5);
    step(1, 0, 1, MB, 32'h43, 1);
    chk("tx_data_43", {24'd0, tx_data}, 32'h43);
    chk("tx_valid_keep", {31'd0, tx_valid}, 32'd1);
    step(0, 1, 3, MB, 0, 1);       chk("tx_read0", data_mem_out, 32'h0);
    chk("tx_drained", {31'd0, tx_valid}, 32'd0);

    do_reset();
    for (int i = 0; i < 9; i++) step(0, 0, 0, 32'h0, 0, 0);
    step(0, 1, 3, MB | 32'h8, 0, 0);
`ifdef DMEM_CYCLE_COUNTER_EN
    chk("cycle_10", data_mem_out, 32'd9);
    step(0, 1, 3, MB | 32'h8, 0, 0); chk("cycle_10b", data_mem_out, 32'd10);
    force dut.cycle_cnt = 32'hFFFFFFFF;
    #1;
    release dut.cycle_cnt;
    m_cycle = 32'hFFFFFFFF;
    step(0, 1, 3, MB | 32'h8, 0, 0); chk("cycle_max", data_mem_out, 32'hFFFFFFFF);
    step(0, 1, 3, MB | 32'h8, 0, 0); chk("cycle_wrap", data_mem_out, 32'h0);
`else
    chk("cycle_off", data_mem_out, 32'h0);
`endif

    for (int i = 0; i < 1024; i++) step(1, 0, 3, 32'(i * 4), $urandom, 0);
    for (int i = 0; i < 2000; i++) begin
      pick = 3'($urandom_range(0, 4));
      if (pick == 3'd0) ra = MB | (32'($urandom_range(0, 4)) << 2);
      else              ra = 32'($urandom_range(0, 16383));
      step(1'($urandom), 1'($urandom), 2'($urandom), ra, $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
